// File: rtl/pattern_runner.sv
// -----------------------------------------------------------------------------
// pattern_runner
//
// Purpose:
//   Applies stimulus/expect/mask pattern words to a device under test (DUT).
//   Each accepted word is driven onto dut_pi, held for SETTLE_CYCLES cycles,
//   and then the DUT outputs are strobed and compared against the expected
//   response under the compare mask. Failures are counted and reported. The
//   index of the first failure is remembered. A summary (done/pass) is held
//   after the word marked "last" until clear or rst.
//
// Parameters:
//   NINPUTS        width of the DUT primary-input vector
//   NOUTPUTS       width of the DUT primary-output vector
//   SETTLE_CYCLES  cycles between applying inputs and strobing (1..255)
//   CNT_W          width of the pattern / fail counters (saturating)
//
// Ports:
//   clk             single clock, rising edge
//   rst             synchronous active-high reset
//   pat_valid       pattern word offered by the source
//   pat_ready       runner accepts a pattern word this cycle
//   pat_pi          stimulus {ain[1:0], bin[1:0], sel}
//   pat_xpct        expected response {zout[1], zout[0]}
//   pat_mask        per-bit compare enable (1 = compare)
//   pat_last        final pattern of the set
//   clear           leaves DONE and zeroes results (ignored elsewhere)
//   dut_pi          registered drive to the DUT inputs
//   dut_po          DUT outputs
//   err_valid       pulse during a failing strobe cycle
//   err_bits        masked mismatch bits, valid while err_valid=1
//   fail_count      number of failing patterns
//   pat_count       number of strobed patterns
//   first_fail_idx  0-based index of the first failing pattern
//   first_fail_vld  first_fail_idx holds a valid index
//   done            pattern set complete
//   pass            done with zero failures
// -----------------------------------------------------------------------------
module pattern_runner #(
    parameter int NINPUTS       = 5,
    parameter int NOUTPUTS      = 2,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pat_valid,
    output logic                pat_ready,
    input  logic [NINPUTS-1:0]  pat_pi,
    input  logic [NOUTPUTS-1:0] pat_xpct,
    input  logic [NOUTPUTS-1:0] pat_mask,
    input  logic                pat_last,
    input  logic                clear,
    output logic [NINPUTS-1:0]  dut_pi,
    input  logic [NOUTPUTS-1:0] dut_po,
    output logic                err_valid,
    output logic [NOUTPUTS-1:0] err_bits,
    output logic [CNT_W-1:0]    fail_count,
    output logic [CNT_W-1:0]    pat_count,
    output logic [CNT_W-1:0]    first_fail_idx,
    output logic                first_fail_vld,
    output logic                done,
    output logic                pass
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_STROBE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Counter load value: the counter reaching zero marks the final settle
    // cycle, so a load of SETTLE_CYCLES-1 gives exactly SETTLE_CYCLES cycles.
    localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_t              r_state;
    logic [7:0]          r_cnt;
    logic [NOUTPUTS-1:0] r_xpct;
    logic [NOUTPUTS-1:0] r_mask;
    logic                r_last;
    logic [NINPUTS-1:0]  r_dut_pi;
    logic                r_pat_ready;
    logic [CNT_W-1:0]    r_fail_count;
    logic [CNT_W-1:0]    r_pat_count;
    logic [CNT_W-1:0]    r_first_fail_idx;
    logic                r_first_fail_vld;
    logic                r_done;
    logic                r_pass;

    logic [NOUTPUTS-1:0] w_mism;
    logic                w_fail;
    logic                w_err_valid;
    logic [NOUTPUTS-1:0] w_err_bits;
    logic [CNT_W-1:0]    w_fail_next;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] res;
        if (v == CNT_MAX) begin
            res = v;
        end else begin
            res = v + CNT_W'(1);
        end
        return res;
    endfunction

    // Strobe compare. Masking with AND forces don't-care bits to 0 even when
    // the DUT drives X/Z there, so they can never flag a failure. The error
    // pulse is combinational so it lines up with the strobe cycle itself,
    // and rst suppresses it so a reset mid-strobe emits nothing.
    always_comb begin
        w_mism      = (dut_po ^ r_xpct) & r_mask;
        w_fail      = |w_mism;
        w_err_valid = 1'b0;
        w_err_bits  = '0;
        w_fail_next = r_fail_count;
        if ((r_state == ST_STROBE) && !rst && w_fail) begin
            w_err_valid = 1'b1;
            w_err_bits  = w_mism;
        end else begin
            w_err_valid = 1'b0;
            w_err_bits  = '0;
        end
        if (w_fail) begin
            w_fail_next = sat_inc(r_fail_count);
        end else begin
            w_fail_next = r_fail_count;
        end
    end

    // Runner FSM with all result registers and registered handshake/status.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_cnt            <= 8'd0;
            r_xpct           <= '0;
            r_mask           <= '0;
            r_last           <= 1'b0;
            r_dut_pi         <= '0;
            r_pat_ready      <= 1'b1;
            r_fail_count     <= '0;
            r_pat_count      <= '0;
            r_first_fail_idx <= '0;
            r_first_fail_vld <= 1'b0;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (pat_valid && r_pat_ready) begin
                        r_dut_pi    <= pat_pi;
                        r_xpct      <= pat_xpct;
                        r_mask      <= pat_mask;
                        r_last      <= pat_last;
                        r_cnt       <= SETTLE_LOAD;
                        r_pat_ready <= 1'b0;
                        r_state     <= ST_SETTLE;
                    end else begin
                        r_pat_ready <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == 8'd0) begin
                        r_state <= ST_STROBE;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                ST_STROBE: begin
                    r_pat_count <= sat_inc(r_pat_count);
                    r_fail_count <= w_fail_next;
                    // Index is the pre-increment pattern count.
                    if (w_fail && !r_first_fail_vld) begin
                        r_first_fail_idx <= r_pat_count;
                        r_first_fail_vld <= 1'b1;
                    end
                    if (r_last) begin
                        r_done      <= 1'b1;
                        r_pass      <= (w_fail_next == '0);
                        r_pat_ready <= 1'b0;
                        r_state     <= ST_DONE;
                    end else begin
                        r_pat_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    // dut_pi intentionally keeps its last value across clear.
                    if (clear) begin
                        r_fail_count     <= '0;
                        r_pat_count      <= '0;
                        r_first_fail_idx <= '0;
                        r_first_fail_vld <= 1'b0;
                        r_done           <= 1'b0;
                        r_pass           <= 1'b0;
                        r_pat_ready      <= 1'b1;
                        r_state          <= ST_IDLE;
                    end else begin
                        r_pat_ready <= 1'b0;
                    end
                end
                default: begin
                    r_pat_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign pat_ready      = r_pat_ready;
    assign dut_pi         = r_dut_pi;
    assign err_valid      = w_err_valid;
    assign err_bits       = w_err_bits;
    assign fail_count     = r_fail_count;
    assign pat_count      = r_pat_count;
    assign first_fail_idx = r_first_fail_idx;
    assign first_fail_vld = r_first_fail_vld;
    assign done           = r_done;
    assign pass           = r_pass;

endmodule

// File: tb/tb_pattern_runner.sv
// -----------------------------------------------------------------------------
// tb_pattern_runner
//
// Directed bench for pattern_runner. Two instances share all inputs: u_dut
// with default parameters and u_sat with CNT_W=2 for counter saturation.
// Expected mismatch bits are queued when a word is accepted and popped at
// the strobe cycle; a small model tracks counters, first-fail index and
// done/pass for both counter widths.
// -----------------------------------------------------------------------------
module tb_pattern_runner;

    localparam int  S = 4;
    localparam time P = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       pat_valid;
    logic [4:0] pat_pi;
    logic [1:0] pat_xpct;
    logic [1:0] pat_mask;
    logic       pat_last;
    logic       clear;
    logic [1:0] dut_po;

    logic        pat_ready;
    logic [4:0]  dut_pi;
    logic        err_valid;
    logic [1:0]  err_bits;
    logic [15:0] fail_count;
    logic [15:0] pat_count;
    logic [15:0] first_fail_idx;
    logic        first_fail_vld;
    logic        done;
    logic        pass;

    logic        s_pat_ready;
    logic [4:0]  s_dut_pi;
    logic        s_err_valid;
    logic [1:0]  s_err_bits;
    logic [1:0]  s_fail_count;
    logic [1:0]  s_pat_count;
    logic [1:0]  s_first_fail_idx;
    logic        s_first_fail_vld;
    logic        s_done;
    logic        s_pass;

    always #(P/2) clk = ~clk;

    pattern_runner #(.NINPUTS(5), .NOUTPUTS(2), .SETTLE_CYCLES(S), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .pat_valid(pat_valid), .pat_ready(pat_ready),
        .pat_pi(pat_pi), .pat_xpct(pat_xpct), .pat_mask(pat_mask), .pat_last(pat_last),
        .clear(clear), .dut_pi(dut_pi), .dut_po(dut_po), .err_valid(err_valid),
        .err_bits(err_bits), .fail_count(fail_count), .pat_count(pat_count),
        .first_fail_idx(first_fail_idx), .first_fail_vld(first_fail_vld),
        .done(done), .pass(pass)
    );

    pattern_runner #(.NINPUTS(5), .NOUTPUTS(2), .SETTLE_CYCLES(S), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .pat_valid(pat_valid), .pat_ready(s_pat_ready),
        .pat_pi(pat_pi), .pat_xpct(pat_xpct), .pat_mask(pat_mask), .pat_last(pat_last),
        .clear(clear), .dut_pi(s_dut_pi), .dut_po(dut_po), .err_valid(s_err_valid),
        .err_bits(s_err_bits), .fail_count(s_fail_count), .pat_count(s_pat_count),
        .first_fail_idx(s_first_fail_idx), .first_fail_vld(s_first_fail_vld),
        .done(s_done), .pass(s_pass)
    );

    int checks = 0;
    int errors = 0;

    logic [1:0] sb_q[$];

    int         exp_pat, exp_fail, exp_ffi;
    int         exp_pat2, exp_fail2, exp_ffi2;
    bit         exp_ffv, exp_done;
    logic [4:0] cur_pi;
    bit         cur_last;
    time        acc_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        exp_pat = 0; exp_fail = 0; exp_ffi = 0;
        exp_pat2 = 0; exp_fail2 = 0; exp_ffi2 = 0;
        exp_ffv = 1'b0; exp_done = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, 32'(pat_ready), 32'd1);
        chk({tag, "_dut_pi"}, 32'(dut_pi), 32'd0);
        chk({tag, "_err_valid"}, 32'(err_valid), 32'd0);
        chk({tag, "_err_bits"}, 32'(err_bits), 32'd0);
        chk({tag, "_fail"}, 32'(fail_count), 32'd0);
        chk({tag, "_pat"}, 32'(pat_count), 32'd0);
        chk({tag, "_ffi"}, 32'(first_fail_idx), 32'd0);
        chk({tag, "_ffv"}, 32'(first_fail_vld), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_pass"}, 32'(pass), 32'd0);
        chk({tag, "_sat_fail"}, 32'(s_fail_count), 32'd0);
    endtask

    task automatic chk_results();
        chk("pat_count", 32'(pat_count), 32'(exp_pat));
        chk("fail_count", 32'(fail_count), 32'(exp_fail));
        chk("first_fail_vld", 32'(first_fail_vld), 32'(exp_ffv));
        if (exp_ffv) chk("first_fail_idx", 32'(first_fail_idx), 32'(exp_ffi));
        chk("done", 32'(done), 32'(exp_done));
        chk("pass", 32'(pass), 32'(exp_done && (exp_fail == 0)));
        chk("ready_after", 32'(pat_ready), 32'(!exp_done));
        chk("sat_pat_count", 32'(s_pat_count), 32'(exp_pat2));
        chk("sat_fail_count", 32'(s_fail_count), 32'(exp_fail2));
        if (exp_ffv) chk("sat_first_fail_idx", 32'(s_first_fail_idx), 32'(exp_ffi2));
        chk("sat_pass", 32'(s_pass), 32'(exp_done && (exp_fail2 == 0)));
    endtask

    // Offer a word and wait (bounded) for its acceptance edge.
    task automatic offer(input logic [4:0] pi, input logic [1:0] xp, input logic [1:0] mk,
                         input logic [1:0] po, input bit lst, input bit hold);
        bit got = 1'b0;
        pat_pi = pi; pat_xpct = xp; pat_mask = mk; pat_last = lst; dut_po = po;
        pat_valid = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if (pat_ready === 1'b1) begin
                @(posedge clk);
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout observed=no_accept expected=accept");
        end
        acc_t    = $time;
        cur_pi   = pi;
        cur_last = lst;
        sb_q.push_back((po ^ xp) & mk);
        if (!hold) begin
            #1;
            pat_valid = 1'b0;
        end
    endtask

    // Follow an accepted word through settle and strobe, then update the model.
    task automatic finish_pat();
        logic [1:0] e;
        for (int k = 1; k <= S; k++) begin
            @(negedge clk);
            chk("settle_dut_pi", 32'(dut_pi), 32'(cur_pi));
            chk("settle_no_err", 32'(err_valid), 32'd0);
            chk("settle_ready", 32'(pat_ready), 32'd0);
        end
        @(negedge clk);
        e = sb_q.pop_front();
        chk("strobe_dut_pi", 32'(dut_pi), 32'(cur_pi));
        chk("strobe_err_valid", 32'(err_valid), 32'(e != 2'b00));
        if (e != 2'b00) chk("strobe_err_bits", 32'(err_bits), 32'(e));
        chk("sat_strobe_err_valid", 32'(s_err_valid), 32'(e != 2'b00));
        @(posedge clk);
        if (e != 2'b00) begin
            if (!exp_ffv) begin
                exp_ffi  = exp_pat;
                exp_ffi2 = exp_pat2;
                exp_ffv  = 1'b1;
            end
            if (exp_fail < 65535) exp_fail = exp_fail + 1;
            if (exp_fail2 < 3) exp_fail2 = exp_fail2 + 1;
        end
        if (exp_pat < 65535) exp_pat = exp_pat + 1;
        if (exp_pat2 < 3) exp_pat2 = exp_pat2 + 1;
        exp_done = cur_last;
        @(negedge clk);
        chk_results();
    endtask

    initial begin
        time t0, t1, t2, tclr;
        rst = 1'b1; pat_valid = 1'b0; pat_pi = 5'd0; pat_xpct = 2'd0; pat_mask = 2'd0;
        pat_last = 1'b0; clear = 1'b0; dut_po = 2'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_zero("reset");

        // Masked mismatch on bit1 only: passes.
        offer(5'b01011, 2'b01, 2'b01, 2'b11, 1'b0, 1'b0);
        finish_pat();

        // Three words back-to-back with pat_valid held high.
        offer(5'b10100, 2'b10, 2'b11, 2'b10, 1'b0, 1'b1);
        t0 = acc_t;
        finish_pat();
        offer(5'b00111, 2'b11, 2'b10, 2'b01, 1'b0, 1'b1);
        t1 = acc_t;
        finish_pat();
        offer(5'b11000, 2'b00, 2'b00, 2'b11, 1'b0, 1'b0);
        t2 = acc_t;
        finish_pat();
        chk("b2b_gap1", 32'(t1 - t0), 32'(6 * P));
        chk("b2b_gap2", 32'(t2 - t1), 32'(6 * P));

        // Unknown value on a masked bit must not fail.
        offer(5'b00001, 2'b00, 2'b01, 2'bx0, 1'b0, 1'b0);
        finish_pat();

        // Reset during settle of the second word of a pair.
        offer(5'b11111, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0);
        finish_pat();
        offer(5'b10101, 2'b00, 2'b11, 2'b11, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_zero("mid_reset");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("post_reset_no_err", 32'(err_valid), 32'd0);
        end
        sb_q.delete();
        model_reset();

        // Single failing last word.
        offer(5'b01001, 2'b00, 2'b01, 2'b01, 1'b1, 1'b0);
        finish_pat();

        // DONE holds and ignores an offered word.
        pat_pi = 5'b00010; pat_xpct = 2'b01; pat_mask = 2'b01; pat_last = 1'b1;
        dut_po = 2'b01; pat_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("done_hold", 32'(done), 32'd1);
            chk("done_ready", 32'(pat_ready), 32'd0);
            chk("done_pat_count", 32'(pat_count), 32'(exp_pat));
            chk("done_dut_pi", 32'(dut_pi), 32'(cur_pi));
        end

        // Clear, then accept on the following edge.
        @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        tclr = $time;
        #1 clear = 1'b0;
        @(negedge clk);
        chk("clear_pat", 32'(pat_count), 32'd0);
        chk("clear_fail", 32'(fail_count), 32'd0);
        chk("clear_ffv", 32'(first_fail_vld), 32'd0);
        chk("clear_done", 32'(done), 32'd0);
        chk("clear_pass", 32'(pass), 32'd0);
        chk("clear_ready", 32'(pat_ready), 32'd1);
        chk("clear_dut_pi_kept", 32'(dut_pi), 32'(cur_pi));
        model_reset();
        offer(5'b00010, 2'b01, 2'b01, 2'b01, 1'b1, 1'b0);
        chk("clear_accept_time", 32'(acc_t - tclr), 32'(P));
        finish_pat();

        // Saturation: five failing words.
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            offer(5'(i), 2'b00, 2'b11, 2'b11, (i == 4), 1'b0);
            finish_pat();
        end
        chk("sat_fail_final", 32'(s_fail_count), 32'd3);
        chk("sat_ffi_final", 32'(s_first_fail_idx), 32'd0);
        chk("wide_fail_final", 32'(fail_count), 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pattern_runner.md
PATTERN_RUNNER -- requirements
Module: pattern_runner

Interface
REQ-001 SHALL have parameter NINPUTS, default 5, the width of the DUT primary-input vector.
REQ-002 SHALL have parameter NOUTPUTS, default 2, the width of the DUT primary-output vector.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 4 (legal 1..255), the number of cycles between applying inputs and strobing outputs.
REQ-004 SHALL have parameter CNT_W, default 16, the width of the pattern and fail counters.
REQ-005 clk  in  1  single clock; all state changes on the rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 pat_valid  in  1  pattern word offered.
REQ-008 pat_ready  out  1  runner accepts a pattern word this cycle.
REQ-009 pat_pi  in  NINPUTS  stimulus; bit order is {ain[1:0], bin[1:0], sel} with MSB = ain[1].
REQ-010 pat_xpct  in  NOUTPUTS  expected response; bit order is {zout[1], zout[0]}.
REQ-011 pat_mask  in  NOUTPUTS  compare enable; 1 = compare the bit, 0 = don't-care.
REQ-012 pat_last  in  1  marks the final pattern of the set.
REQ-013 clear  in  1  leaves DONE and zeroes results; ignored in other states.
REQ-014 dut_pi  out  NINPUTS  registered drive to the DUT inputs.
REQ-015 dut_po  in  NOUTPUTS  DUT outputs.
REQ-016 err_valid  out  1  one-cycle pulse for a failing strobe.
REQ-017 err_bits  out  NOUTPUTS  masked mismatch bits; valid while err_valid=1.
REQ-018 fail_count  out  CNT_W  number of failing patterns.
REQ-019 pat_count  out  CNT_W  number of strobed patterns.
REQ-020 first_fail_idx  out  CNT_W  index (0-based) of the first failing pattern.
REQ-021 first_fail_vld  out  1  first_fail_idx holds a valid index.
REQ-022 done  out  1  pattern set complete.
REQ-023 pass  out  1  done and fail_count==0.

Function
REQ-024 SHALL implement the FSM states IDLE, SETTLE, STROBE and DONE.
REQ-025 IDLE: pat_ready=1; on pat_valid&pat_ready the runner SHALL load dut_pi<=pat_pi, latch xpct, mask and last, load the settle counter with SETTLE_CYCLES-1, and go to SETTLE.
REQ-026 SETTLE: pat_ready=0; dut_pi SHALL be held stable; the counter decrements each cycle; the runner SHALL go to STROBE on the cycle the counter is 0.
REQ-027 STROBE: the runner SHALL compute mism=(dut_po^xpct)&mask.
REQ-028 STROBE: pat_count SHALL increment.
REQ-029 STROBE, mism!=0: err_valid=1 and err_bits=mism for exactly this cycle, and fail_count SHALL increment.
REQ-030 STROBE, mism!=0 with first_fail_vld=0: first_fail_idx<=pat_count (pre-increment value) and first_fail_vld<=1.
REQ-031 STROBE exit: the runner SHALL go to DONE if the latched last=1, otherwise to IDLE.
REQ-032 Latency: pattern accepted at edge T, dut_pi valid after T, dut_po compared in the cycle ending at edge T+SETTLE_CYCLES+1; next pattern accepted no earlier than edge T+SETTLE_CYCLES+2.
REQ-033 DONE: done=1, pass=(fail_count==0), pat_ready=0; the state and all results SHALL hold until clear or rst.
REQ-034 clear in DONE: the runner SHALL zero all counters, first_fail_vld, done and pass, and return to IDLE next cycle; dut_pi SHALL keep its last value.
REQ-035 fail_count and pat_count SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-036 Masked-out bits SHALL never cause a failure, even if dut_po is X or Z.
REQ-037 pat_valid while pat_ready=0 SHALL be ignored; the source holds the word until it is accepted.
REQ-038 err_valid SHALL be 0 in every state except STROBE.

Reset
REQ-039 rst SHALL override all activity, including mid-SETTLE and mid-STROBE, with no error pulse emitted.
REQ-040 On rst the runner SHALL enter state IDLE with pat_ready=1 on the next cycle.
REQ-041 On rst dut_pi, err_valid, err_bits, fail_count, pat_count, first_fail_idx, first_fail_vld, done and pass SHALL all go to 0.

Verification
REQ-042 Pattern pi=01011, xpct=01, mask=01, last=0, DUT drives po=11 -> no err_valid; pat_count=1; fail_count=0.
REQ-043 Pattern pi=01001, xpct=00, mask=01, last=1, po=01 -> err_valid pulse with err_bits=01; fail_count=1; first_fail_idx=0; done=1; pass=0.
REQ-044 Three patterns back-to-back with pat_valid held high, SETTLE_CYCLES=4 -> accepts spaced exactly 6 cycles apart; dut_pi stable for the 5 cycles after each accept.
REQ-045 rst asserted during SETTLE of pattern 2 -> no err_valid; all outputs 0; pat_ready=1 on the next cycle.
REQ-046 DONE, then clear=1 for one cycle -> counters 0, done=0, IDLE; a new pattern is accepted on the following cycle.
REQ-047 CNT_W=2, five failing patterns -> fail_count stays at 3; first_fail_idx=0.
